fc_layer_folded: RTL and testbench

- Time-multiplexed fully-connected layer. Computes NUM_NEURON neurons with NUM_PE parallel MAC engines over ceil-free passes (NUM_NEURON divisible by NUM_PE).
- Drop-in successor to the one-neuron-per-instance layers. Serial input stream in; serial, indexed, back-pressured output stream out.
- Weights and biases load at runtime through the shared config bus.

---
 rtl/fc_layer_folded_pkg.sv | 43 ++++
 rtl/fc_layer_folded_if.sv | 35 +++
 rtl/fc_layer_folded_pe.sv | 48 ++++
 rtl/fc_layer_folded.sv | 224 ++++++++++++++++++++++
 tb/tb_fc_layer_folded.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fc_layer_folded_pkg.sv
// Shared types and helpers for the folded fully-connected layer.
//   state_t    : controller states FILL / COMPUTE / ACT / DRAIN
//   SUM_W      : width of the post-accumulate finalize datapath
//   acc_width  : accumulator width that cannot overflow for a given vector length
//   sat_round  : arithmetic right shift, saturate to DATA_W, optional ReLU
package fc_layer_pkg;

   typedef enum logic [1:0] {FILL, COMPUTE, ACT, DRAIN} state_t;

   // Finalize arithmetic is done at a fixed wide width so a single
   // non-parameterized helper serves every layer configuration.
   localparam int SUM_W = 64;

   function automatic int acc_width(input int data_w, input int num_weight);
      return 2*data_w + $clog2(num_weight) + 1;
   endfunction

   function automatic logic signed [SUM_W-1:0] sat_round(
      input  logic signed [SUM_W-1:0] sum,
      input  int                      frac_w,
      input  int                      data_w,
      input  bit                      relu,
      output bit                      clipped);
      logic signed [SUM_W-1:0] sh, hi, lo, r;
      sh      = sum >>> frac_w;
      hi      = (64'sd1 <<< (data_w-1)) - 64'sd1;
      lo      = -(64'sd1 <<< (data_w-1));
      clipped = 1'b0;
      if (sh > hi) begin
         r       = hi;
         clipped = 1'b1;
      end else if (sh < lo) begin
         r       = lo;
         clipped = 1'b1;
      end else begin
         r = sh;
      end
      // ReLU is applied after clipping, so the clip flag is activation-independent
      if (relu && (r < 64'sd0)) r = 64'sd0;
      return r;
   endfunction

endpackage

// File: rtl/fc_layer_folded_if.sv
// Bus bundle for fc_layer_folded: config write bus, input sample stream,
// indexed output stream.
//   master : producer/consumer side (drives config, x stream, o_ready)
//   slave  : layer side (drives x_ready and the output stream)
interface fc_layer_folded_if #(
   parameter int DATA_W = 16,
   parameter int IDX_W  = 4
);
   logic              weightValid;
   logic              biasValid;
   logic [31:0]       weightValue;
   logic [31:0]       biasValue;
   logic [31:0]       config_layer_num;
   logic [31:0]       config_neuron_num;
   logic              x_valid;
   logic              x_ready;
   logic [DATA_W-1:0] x_in;
   logic              o_valid;
   logic              o_ready;
   logic [DATA_W-1:0] o_data;
   logic [IDX_W-1:0]  o_idx;
   logic              o_last;

   modport master (
      output weightValid, biasValid, weightValue, biasValue,
             config_layer_num, config_neuron_num, x_valid, x_in, o_ready,
      input  x_ready, o_valid, o_data, o_idx, o_last
   );

   modport slave (
      input  weightValid, biasValid, weightValue, biasValue,
             config_layer_num, config_neuron_num, x_valid, x_in, o_ready,
      output x_ready, o_valid, o_data, o_idx, o_last
   );
endinterface

// File: rtl/fc_layer_folded_pe.sv
// fc_pe: one MAC engine of the folded layer.
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear accumulator (held while the controller is not computing)
//   en       : accumulate x*w this cycle
//   x, w     : signed DATA_W operands (already registered by the caller)
//   bias     : signed DATA_W bias, aligned to the product scale internally
//   res      : finalized neuron output (shift, saturate, optional ReLU)
//   clipped  : res was clipped by saturation
module fc_pe
   import fc_layer_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int FRAC_W   = 12,
   parameter int ACC_W    = 37,
   parameter int ACT_RELU = 1
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     en,
   input  logic signed [DATA_W-1:0] x,
   input  logic signed [DATA_W-1:0] w,
   input  logic signed [DATA_W-1:0] bias,
   output logic        [DATA_W-1:0] res,
   output logic                     clipped
);

   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    acc;
   logic signed [SUM_W-1:0]    sum, rnd;

   assign prod = x * w;

   always_ff @(posedge clk) begin
      if (rst || clr) acc <= '0;
      else if (en)    acc <= acc + ACC_W'(prod);
   end

   // Bias is Q(FRAC_W) while the accumulator is Q(2*FRAC_W): align before adding.
   always_comb begin
      clipped = 1'b0;
      sum     = SUM_W'(acc) + (SUM_W'(bias) <<< FRAC_W);
      rnd     = sat_round(sum, FRAC_W, DATA_W, ACT_RELU != 0, clipped);
   end

   assign res = rnd[DATA_W-1:0];

endmodule

// File: rtl/fc_layer_folded.sv
// fc_layer_folded: time-multiplexed fully-connected layer. NUM_PE MAC engines
// evaluate NUM_NEURON neurons in NUM_NEURON/NUM_PE passes over one buffered
// input vector; results leave as an indexed, back-pressured stream.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fc_layer_folded_if.slave (config writes, x stream, o stream)
//   sat_cnt  : [15:0] sticky count of saturated results, only present when
//              FC_LAYER_SAT_STATUS_EN is defined
module fc_layer_folded
   import fc_layer_pkg::*;
#(
   parameter int NUM_NEURON   = 10,
   parameter int NUM_WEIGHT   = 10,
   parameter int NUM_PE       = 2,
   parameter int DATA_W       = 16,
   parameter int WEIGHT_INT_W = 4,
   parameter int LAYER_NUM    = 4,
   parameter int ACT_RELU     = 1
)(
   input  logic                clk,
   input  logic                rst,
   fc_layer_folded_if.slave    bus
`ifdef FC_LAYER_SAT_STATUS_EN
   ,
   output logic [15:0]         sat_cnt
`endif
);

   localparam int FRAC_W = DATA_W - WEIGHT_INT_W;
   localparam int ACC_W  = acc_width(DATA_W, NUM_WEIGHT);
   localparam int NPASS  = NUM_NEURON / NUM_PE;
   localparam int IDX_W  = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;
   localparam int K_W    = $clog2(NUM_WEIGHT + 1);
   localparam int PASS_W = (NPASS > 1) ? $clog2(NPASS) : 1;
   localparam int D_W    = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

   localparam logic [K_W-1:0]    K_LAST    = K_W'(NUM_WEIGHT - 1);
   localparam logic [K_W-1:0]    K_END     = K_W'(NUM_WEIGHT);
   localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NPASS - 1);
   localparam logic [D_W-1:0]    D_LAST    = D_W'(NUM_PE - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_NEURON - 1);
   localparam logic [31:0]       LAYER_ID  = 32'(LAYER_NUM);
   localparam logic [31:0]       NN_32     = 32'(NUM_NEURON);

   if (NUM_NEURON % NUM_PE != 0) begin : g_bad_pe
      $error("fc_layer_folded: NUM_NEURON must be a multiple of NUM_PE");
   end
   if (ACC_W > SUM_W) begin : g_bad_acc
      $error("fc_layer_folded: accumulator wider than finalize datapath");
   end

   // ---------------- config write path (memories are not reset) ----------
   logic [DATA_W-1:0] wmem [NUM_NEURON][NUM_WEIGHT];
   logic [DATA_W-1:0] bmem [NUM_NEURON];
   logic [K_W-1:0]    wcnt;
   logic              tgt_ok, w_acc, b_acc;
   logic [IDX_W-1:0]  cfg_n;

   assign tgt_ok = (bus.config_layer_num == LAYER_ID) && (bus.config_neuron_num < NN_32);
   assign w_acc  = bus.weightValid && tgt_ok;
   assign b_acc  = bus.biasValid   && tgt_ok;
   assign cfg_n  = bus.config_neuron_num[IDX_W-1:0];

   always_ff @(posedge clk) begin
      if (w_acc) wmem[cfg_n][wcnt] <= bus.weightValue[DATA_W-1:0];
      if (b_acc) bmem[cfg_n]       <= bus.biasValue[DATA_W-1:0];
   end

   // A bias write marks the start of a neuron's weight burst.
   always_ff @(posedge clk) begin
      if (rst)        wcnt <= '0;
      else if (b_acc) wcnt <= '0;
      else if (w_acc) wcnt <= (wcnt == K_LAST) ? '0 : wcnt + 1'b1;
   end

   // ---------------- controller ------------------------------------------
   state_t                          state;
   logic [K_W-1:0]                  icnt, kcnt;
   logic [PASS_W-1:0]               pass;
   logic [D_W-1:0]                  dcnt;
   logic                            mac_en, acc_clr;
   logic [DATA_W-1:0]               xbuf [NUM_WEIGHT];
   logic [DATA_W-1:0]               x_q;
   logic [NUM_PE-1:0][DATA_W-1:0]   w_q, b_q, res, res_q;
   logic [NUM_PE-1:0][IDX_W-1:0]    nidx;
   logic [NUM_PE-1:0]               clip;

   for (genvar j = 0; j < NUM_PE; j++) begin : g_nidx
      assign nidx[j] = IDX_W'(int'(pass) * NUM_PE + j);
   end

   // Accumulators are held clear outside COMPUTE/ACT so every pass starts at 0.
   assign acc_clr = (state == FILL) || (state == DRAIN);

   always_ff @(posedge clk) begin
      if (state == FILL && bus.x_valid && bus.x_ready) xbuf[icnt] <= bus.x_in;
   end

   // Registered read port: operands for tap k are presented one cycle later.
   always_ff @(posedge clk) begin
      if (state == COMPUTE && kcnt != K_END) begin
         x_q <= xbuf[kcnt];
         for (int j = 0; j < NUM_PE; j++) begin
            w_q[j] <= wmem[nidx[j]][kcnt];
            b_q[j] <= bmem[nidx[j]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= FILL;
         icnt        <= '0;
         kcnt        <= '0;
         pass        <= '0;
         dcnt        <= '0;
         mac_en      <= 1'b0;
         res_q       <= '0;
         bus.x_ready <= 1'b1;
         bus.o_valid <= 1'b0;
         bus.o_data  <= '0;
         bus.o_idx   <= '0;
         bus.o_last  <= 1'b0;
      end else begin
         mac_en <= 1'b0;
         case (state)
            FILL: begin
               if (bus.x_valid && bus.x_ready) begin
                  if (icnt == K_LAST) begin
                     icnt        <= '0;
                     kcnt        <= '0;
                     pass        <= '0;
                     bus.x_ready <= 1'b0;
                     state       <= COMPUTE;
                  end else begin
                     icnt <= icnt + 1'b1;
                  end
               end
            end
            COMPUTE: begin
               // NUM_WEIGHT issue cycles plus one to absorb the read latency
               if (kcnt == K_END) begin
                  kcnt  <= '0;
                  state <= ACT;
               end else begin
                  mac_en <= 1'b1;
                  kcnt   <= kcnt + 1'b1;
               end
            end
            ACT: begin
               res_q       <= res;
               bus.o_valid <= 1'b1;
               bus.o_data  <= res[0];
               bus.o_idx   <= nidx[0];
               bus.o_last  <= (nidx[0] == IDX_LAST);
               dcnt        <= '0;
               state       <= DRAIN;
            end
            DRAIN: begin
               if (bus.o_ready) begin
                  if (dcnt == D_LAST) begin
                     dcnt        <= '0;
                     bus.o_valid <= 1'b0;
                     bus.o_last  <= 1'b0;
                     if (pass == PASS_LAST) begin
                        pass        <= '0;
                        bus.x_ready <= 1'b1;
                        state       <= FILL;
                     end else begin
                        pass  <= pass + 1'b1;
                        state <= COMPUTE;
                     end
                  end else begin
                     dcnt       <= dcnt + 1'b1;
                     bus.o_data <= res_q[dcnt + 1'b1];
                     bus.o_idx  <= bus.o_idx + 1'b1;
                     bus.o_last <= ((bus.o_idx + 1'b1) == IDX_LAST);
                  end
               end
            end
            default: state <= FILL;
         endcase
      end
   end

   // ---------------- MAC engines -----------------------------------------
   for (genvar j = 0; j < NUM_PE; j++) begin : g_pe
      fc_pe #(
         .DATA_W   (DATA_W),
         .FRAC_W   (FRAC_W),
         .ACC_W    (ACC_W),
         .ACT_RELU (ACT_RELU)
      ) u_pe (
         .clk     (clk),
         .rst     (rst),
         .clr     (acc_clr),
         .en      (mac_en),
         .x       (x_q),
         .w       (w_q[j]),
         .bias    (b_q[j]),
         .res     (res[j]),
         .clipped (clip[j])
      );
   end

`ifdef FC_LAYER_SAT_STATUS_EN
   logic [16:0] sat_sum;
   always_comb begin
      sat_sum = {1'b0, sat_cnt};
      for (int j = 0; j < NUM_PE; j++) sat_sum = sat_sum + 17'(clip[j]);
   end

   always_ff @(posedge clk) begin
      if (rst)                sat_cnt <= '0;
      else if (state == ACT)  sat_cnt <= (sat_sum > 17'h0FFFF) ? 16'hFFFF : sat_sum[15:0];
   end

   logic unused_bits;
   assign unused_bits = ^{bus.weightValue[31:DATA_W], bus.biasValue[31:DATA_W]};
`else
   logic unused_bits;
   assign unused_bits = ^{bus.weightValue[31:DATA_W], bus.biasValue[31:DATA_W], clip};
`endif

endmodule

// File: tb/tb_fc_layer_folded.sv
module tb_fc_layer_folded;
   localparam int NN = 4, NW = 3, NP = 2, DW = 16, IW = 4, IDXW = 2, LAYER = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fc_layer_folded_if #(.DATA_W(DW), .IDX_W(IDXW)) bus ();
   fc_layer_folded_if #(.DATA_W(DW), .IDX_W(IDXW)) bus_lin ();

   // Second instance with identity activation runs in lockstep on the same stimulus.
   assign bus_lin.weightValid       = bus.weightValid;
   assign bus_lin.biasValid         = bus.biasValid;
   assign bus_lin.weightValue       = bus.weightValue;
   assign bus_lin.biasValue         = bus.biasValue;
   assign bus_lin.config_layer_num  = bus.config_layer_num;
   assign bus_lin.config_neuron_num = bus.config_neuron_num;
   assign bus_lin.x_valid           = bus.x_valid;
   assign bus_lin.x_in              = bus.x_in;
   assign bus_lin.o_ready           = bus.o_ready;

`ifdef FC_LAYER_SAT_STATUS_EN
   logic [15:0] sat_cnt, sat_cnt_lin;
`endif

   fc_layer_folded #(.NUM_NEURON(NN), .NUM_WEIGHT(NW), .NUM_PE(NP), .DATA_W(DW),
                     .WEIGHT_INT_W(IW), .LAYER_NUM(LAYER), .ACT_RELU(1)) dut (
      .clk (clk), .rst (rst), .bus (bus)
`ifdef FC_LAYER_SAT_STATUS_EN
      , .sat_cnt (sat_cnt)
`endif
   );

   fc_layer_folded #(.NUM_NEURON(NN), .NUM_WEIGHT(NW), .NUM_PE(NP), .DATA_W(DW),
                     .WEIGHT_INT_W(IW), .LAYER_NUM(LAYER), .ACT_RELU(0)) dut_lin (
      .clk (clk), .rst (rst), .bus (bus_lin)
`ifdef FC_LAYER_SAT_STATUS_EN
      , .sat_cnt (sat_cnt_lin)
`endif
   );

   int passed = 0, total = 0;

   // Reference model state: signed values as plain integers
   int wm [NN][NW];
   int bm [NN];
   int xm [NW];
   int mwcnt = 0;
   int sat_model = 0;

   function automatic int s16(input int v);
      logic signed [15:0] t;
      t = v[15:0];
      return int'(t);
   endfunction

   // Q4.12 neuron: sum(x*w) + b*4096, floor-divide by 4096, clip, optional ReLU
   function automatic int ref_out(input int n, input bit relu, output bit clip);
      longint acc = 0;
      for (int k = 0; k < NW; k++) acc += longint'(xm[k]) * longint'(wm[n][k]);
      acc += longint'(bm[n]) * 4096;
      acc = acc >>> 12;
      clip = 1'b0;
      if (acc > 32767)       begin acc = 32767;  clip = 1'b1; end
      else if (acc < -32768) begin acc = -32768; clip = 1'b1; end
      if (relu && acc < 0) acc = 0;
      return int'(acc);
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wr_bias(input int layer, input int neuron, input int val);
      bus.biasValid = 1'b1; bus.biasValue = 32'(val);
      bus.config_layer_num = 32'(layer); bus.config_neuron_num = 32'(neuron);
      tick();
      bus.biasValid = 1'b0;
      if (layer == LAYER && neuron < NN) begin bm[neuron] = s16(val); mwcnt = 0; end
   endtask

   task automatic wr_weight(input int layer, input int neuron, input int val);
      bus.weightValid = 1'b1; bus.weightValue = 32'(val);
      bus.config_layer_num = 32'(layer); bus.config_neuron_num = 32'(neuron);
      tick();
      bus.weightValid = 1'b0;
      if (layer == LAYER && neuron < NN) begin
         wm[neuron][mwcnt] = s16(val);
         mwcnt = (mwcnt + 1) % NW;
      end
   endtask

   task automatic load_neuron(input int n, input int w0, input int w1, input int w2, input int b);
      wr_bias(LAYER, n, b);
      wr_weight(LAYER, n, w0);
      wr_weight(LAYER, n, w1);
      wr_weight(LAYER, n, w2);
   endtask

   task automatic send_frame(input int x0, input int x1, input int x2);
      int xs[NW];
      int g;
      xs = '{x0, x1, x2};
      for (int k = 0; k < NW; k++) begin
         bus.x_valid = 1'b1; bus.x_in = 16'(xs[k]); xm[k] = s16(xs[k]);
         g = 0;
         while (!bus.x_ready && g < 200) begin tick(); g++; end
         if (g >= 200) begin total++; $display("FAIL x_ready_timeout sample %0d: x_ready=%b required 1", k, bus.x_ready); end
         tick();
      end
      bus.x_valid = 1'b0;
   endtask

   // Drain all NN outputs, checking every valid cycle against the model.
   task automatic collect(input string tag, input bit rnd_stall);
      int i = 0, g = 0, e, el;
      bit clip;
      while (i < NN && g < 500) begin
         bus.o_ready = rnd_stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (bus.o_valid) begin
            e  = ref_out(i, 1'b1, clip);
            el = ref_out(i, 1'b0, clip);
            total++;
            if (bus.o_data !== 16'(e) || bus.o_idx !== IDXW'(i) || bus.o_last !== (i == NN-1))
               $display("FAIL %s out%0d: data=%h idx=%0d last=%b required data=%h idx=%0d last=%b",
                        tag, i, bus.o_data, bus.o_idx, bus.o_last, 16'(e), i, (i == NN-1));
            else passed++;
            total++;
            if (bus_lin.o_valid !== 1'b1 || bus_lin.o_data !== 16'(el))
               $display("FAIL %s lin_out%0d: valid=%b data=%h required valid=1 data=%h",
                        tag, i, bus_lin.o_valid, bus_lin.o_data, 16'(el));
            else passed++;
            if (bus.o_ready) i++;
         end
         tick(); g++;
      end
      bus.o_ready = 1'b1;
      if (i < NN) begin total++; $display("FAIL %s drain_timeout: got %0d outputs required %0d", tag, i, NN); end
      for (int n = 0; n < NN; n++) begin
         void'(ref_out(n, 1'b1, clip));
         if (clip && sat_model < 65535) sat_model++;
      end
   endtask

   task automatic check_sat(input string tag);
`ifdef FC_LAYER_SAT_STATUS_EN
      total++;
      if (sat_cnt !== 16'(sat_model) || sat_cnt_lin !== 16'(sat_model))
         $display("FAIL %s sat_cnt: relu=%0d lin=%0d required %0d", tag, sat_cnt, sat_cnt_lin, sat_model);
      else passed++;
`else
      if (tag.len() == 0) $display("empty tag");
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      mwcnt = 0; sat_model = 0;
      total++; if (bus.x_ready !== 1'b1) $display("FAIL reset_x_ready: %b required 1", bus.x_ready); else passed++;
      total++; if (bus.o_valid !== 1'b0) $display("FAIL reset_o_valid: %b required 0", bus.o_valid); else passed++;
      total++; if (bus.o_data !== 16'h0) $display("FAIL reset_o_data: %h required 0000", bus.o_data); else passed++;
      total++; if (bus.o_idx !== 2'd0) $display("FAIL reset_o_idx: %0d required 0", bus.o_idx); else passed++;
      total++; if (bus.o_last !== 1'b0) $display("FAIL reset_o_last: %b required 0", bus.o_last); else passed++;
      check_sat("reset");
   endtask

   task automatic test_basic();
      int cyc = 0;
      for (int n = 0; n < NN; n++) load_neuron(n, 16'h1000, 16'h1000, 16'h1000, 0);
      send_frame(16'h1000, 16'h2000, 16'h0800);
      // first result appears NW+2 edges after the edge that takes the last sample
      while (!bus.o_valid && cyc < 50) begin tick(); cyc++; end
      total++;
      if (cyc != NW + 2) $display("FAIL latency: %0d edges required %0d", cyc, NW + 2);
      else passed++;
      collect("basic", 1'b0);
   endtask

   task automatic test_relu_neg();
      load_neuron(2, 16'hF000, 16'hF000, 16'hF000, 16'h0100);
      send_frame(16'h1000, 16'h2000, 16'h0800);
      collect("relu", 1'b0);
   endtask

   task automatic test_saturation();
      load_neuron(2, 16'h1000, 16'h1000, 16'h1000, 0);
      send_frame(16'h7000, 16'h7000, 16'h7000);
      collect("sat", 1'b0);
      check_sat("sat");
   endtask

   task automatic test_backpressure();
      int g = 0, e;
      bit clip;
      bus.o_ready = 1'b0;
      send_frame(16'h1000, 16'h2000, 16'h0800);
      while (!bus.o_valid && g < 50) begin tick(); g++; end
      e = ref_out(0, 1'b1, clip);
      for (int c = 0; c < 5; c++) begin
         tick();
         total++;
         if (bus.o_valid !== 1'b1 || bus.o_data !== 16'(e) || bus.o_idx !== 2'd0 || bus.x_ready !== 1'b0)
            $display("FAIL stall%0d: valid=%b data=%h idx=%0d x_ready=%b required 1 %h 0 0",
                     c, bus.o_valid, bus.o_data, bus.o_idx, bus.x_ready, 16'(e));
         else passed++;
      end
      collect("bp", 1'b0);
      total++;
      if (bus.x_ready !== 1'b1 || bus.o_valid !== 1'b0)
         $display("FAIL bp_release: x_ready=%b o_valid=%b required 1 0", bus.x_ready, bus.o_valid);
      else passed++;
   endtask

   task automatic test_reset_mid();
      send_frame(16'h0C00, 16'hF400, 16'h2100);
      tick(); tick();
      rst = 1'b1; tick(); rst = 1'b0;
      mwcnt = 0; sat_model = 0;
      total++;
      if (bus.o_valid !== 1'b0 || bus.x_ready !== 1'b1)
         $display("FAIL rst_mid: o_valid=%b x_ready=%b required 0 1", bus.o_valid, bus.x_ready);
      else passed++;
      check_sat("rst_mid");
      send_frame(16'h0C00, 16'hF400, 16'h2100);
      collect("rst_mid", 1'b0);
   endtask

   task automatic test_bad_config();
      for (int k = 0; k < 4; k++) begin
         wr_weight(3, k % NN, int'($urandom_range(0, 65535)));
         wr_weight(LAYER, NN + k, int'($urandom_range(0, 65535)));
      end
      wr_bias(3, 1, int'($urandom_range(0, 65535)));
      wr_bias(LAYER, NN, int'($urandom_range(0, 65535)));
      send_frame(16'h0C00, 16'hF400, 16'h2100);
      collect("badcfg", 1'b1);
   endtask

   task automatic test_random();
      int span;
      for (int it = 0; it < 5; it++) begin
         span = (it == 4) ? 32'h7FFF : 32'h1800;
         for (int n = 0; n < NN; n++)
            load_neuron(n, int'($urandom_range(0, 2*span)) - span, int'($urandom_range(0, 2*span)) - span,
                        int'($urandom_range(0, 2*span)) - span, int'($urandom_range(0, 2*span)) - span);
         send_frame(int'($urandom_range(0, 2*span)) - span, int'($urandom_range(0, 2*span)) - span,
                    int'($urandom_range(0, 2*span)) - span);
         collect("rand", 1'b1);
      end
      check_sat("rand");
   endtask

   initial begin
      rst = 1'b1;
      bus.weightValid = 1'b0; bus.biasValid = 1'b0;
      bus.weightValue = '0;   bus.biasValue = '0;
      bus.config_layer_num = '0; bus.config_neuron_num = '0;
      bus.x_valid = 1'b0; bus.x_in = '0; bus.o_ready = 1'b1;
      test_reset();
      test_basic();
      test_relu_neg();
      test_saturation();
      test_backpressure();
      test_reset_mid();
      test_bad_config();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
